// File: rtl/tff_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop modulo counter.
// Imported by the counter RTL and by its bench.
package tff_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  // Largest legal count for a given modulus.
  function automatic int max_count(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle of the modulo counter.
// T exposes the per-bit toggle enables so checkers can observe the toggle datapath.
interface tff_mod_counter_if #(
  parameter int WIDTH = tff_counter_pkg::DEFAULT_WIDTH
);
  // There is no valid/ready handshake: the counter samples En/Up/Load/D on every
  // falling edge of Clock with no backpressure. Q is registered, while TC and T are
  // combinational views of the decision that the next falling edge will commit.
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic [WIDTH-1:0] T;

  modport master (output En, Up, Load, D, input Q, TC, T);
  modport slave  (input En, Up, Load, D, output Q, TC, T);
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on the falling edge of Clock when T=1.
// Asynchronous active-high reset clears the bit to 0.
module tff_cell (
  input  logic Clock,
  input  logic Reset,
  input  logic T,
  output logic Q
);

  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter with parallel load, built from WIDTH T cells.
// Define TFF_COUNTER_SAT_EN to make the counter saturate at its ends instead of wrapping.
module tff_mod_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic                Clock,
  input  logic                Reset,
  tff_mod_counter_if.slave    bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULUS));
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] down_wrap;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

`ifdef TFF_COUNTER_SAT_EN
  assign up_wrap   = MAX_Q;
  assign down_wrap = '0;
`else
  assign up_wrap   = '0;
  assign down_wrap = MAX_Q;
`endif

  // Load beats count; an out-of-range load value clamps to 0 so Q stays legal.
  always_comb begin
    next_q = q;
    if (bus.Load) begin
      next_q = ({1'b0, bus.D} < MOD_X) ? bus.D : '0;
    end else if (bus.En) begin
      if (bus.Up) begin
        next_q = at_max ? up_wrap : q + WIDTH'(1);
      end else begin
        next_q = at_zero ? down_wrap : q - WIDTH'(1);
      end
    end
  end

  // Each bit only ever changes by toggling its cell.
  assign t = next_q ^ q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    tff_cell u_cell (
      .Clock (Clock),
      .Reset (Reset),
      .T     (t[i]),
      .Q     (q[i])
    );
  end

  assign bus.Q  = q;
  assign bus.T  = t;
  assign bus.TC = bus.En & ~Reset & ((bus.Up & at_max) | (~bus.Up & at_zero));

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter (WIDTH=4, MODULUS=10): directed steps push expectations,
// a monitor checks TC/T before each falling edge and Q after it.
module tb_tff_mod_counter;
  import tff_counter_pkg::*;

`ifdef TFF_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int W = 10;  // {chk_t, t[3:0], tc, q[3:0]}

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  tff_mod_counter_if #(.WIDTH(DEFAULT_WIDTH)) bus ();

  tff_mod_counter #(.WIDTH(DEFAULT_WIDTH), .MODULUS(DEFAULT_MODULUS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #20 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; the falling edge commits them.
  task automatic step(input logic en, input logic up, input logic load,
                      input logic [3:0] d, input logic [3:0] q_after,
                      input logic tc_before, input logic chk_t, input logic [3:0] t_before);
    @(posedge Clock);
    #1;
    bus.En   = en;
    bus.Up   = up;
    bus.Load = load;
    bus.D    = d;
    exp_q.push_back({chk_t, t_before, tc_before, q_after});
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge Clock);
      #10;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("tc_before_edge", int'(bus.TC), int'(e[4]));
        if (e[9]) check("toggle_bits", int'(bus.T), int'(e[8:5]));
        @(negedge Clock);
        #5;
        e = exp_q.pop_front();
        check("q_after_edge", int'(bus.Q), int'(e[3:0]));
      end
    end
  end

  // Driver
  initial begin
    int mx;
    mx       = max_count(DEFAULT_MODULUS);
    n_checks = 0;
    n_fail   = 0;
    bus.En   = 1'b0;
    bus.Up   = 1'b1;
    bus.Load = 1'b0;
    bus.D    = '0;
    Reset    = 1'b1;
    #5;
    check("reset_q", int'(bus.Q), 0);
    check("reset_tc", int'(bus.TC), 0);
    #5;
    Reset = 1'b0;

    // Idle after reset holds 0
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'b0000);

    // Count up through the terminal count
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0,
           (k == 10) ? (SAT ? 4'(mx) : 4'd0) : 4'(k),
           (k == 10), 1'b0, 4'b0000);
    end

    // Back to 0, then down from 0
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 4'd0, SAT ? 4'd0 : 4'd9, 1'b1, 1'b0, 4'b0000);

    // Load wins over En; TC still reflects En/Up at the current Q
    step(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, SAT ? 1'b0 : 1'b1, 1'b0, 4'b0000);

    // Toggle datapath: 7->8 flips all bits, 8->9 bit 0, 9->0 bits 0 and 3
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 1'b0, 4'd0, SAT ? 4'd9 : 4'd0, 1'b1, 1'b1,
         SAT ? 4'b0000 : 4'b1001);

    // Out-of-range loads clamp to 0
    step(1'b0, 1'b1, 1'b1, 4'd12, 4'd0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 4'd15, 4'd0, 1'b0, 1'b1, 4'b1001);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'b0000);

    // Count to 5, then pulse reset between edges
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'(k), 1'b0, 1'b0, 4'b0000);
    @(negedge Clock);
    #8;
    bus.En = 1'b1;
    bus.Up = 1'b0;
    Reset  = 1'b1;
    #1;
    check("async_reset_q", int'(bus.Q), 0);
    check("reset_masks_tc", int'(bus.TC), 0);
    #19;
    bus.En = 1'b0;
    Reset  = 1'b0;
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 4'b0000);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
Synchronous modulo-N up/down counter built from a bank of T flip-flop cells. It is the downstream consumer stage of the T FF: per-bit toggle enables are computed combinationally from the current count, and each bit is held in a T cell clocked on the falling edge of Clock. Provides parallel load and a terminal-count output for cascading.

Parameters:
WIDTH, 4, count register width in bits
MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise

Ports:
Clock  input  1  clock; all state updates on the falling edge
Reset  input  1  asynchronous, active-high reset
En     input  1  count enable
Up     input  1  direction: 1 = increment, 0 = decrement
Load   input  1  synchronous parallel load
D      input  WIDTH  load value
Q      output  WIDTH  current count
TC     output  1  terminal count (combinational)

Behaviour:
- Reset=1: Q=0 immediately, without waiting for an edge. TC forced to 0 while Reset=1. Reset mid-operation discards the count. After release, counting resumes from 0 on the next falling edge.
- Priority at each falling edge: Reset > Load > En. With none active, Q holds.
- Load=1: Q <= D if D < MODULUS, else Q <= 0. Load ignores En and Up.
- En=1 and Up=1: if Q == MODULUS-1 then Q <= 0, else Q <= Q+1.
- En=1 and Up=0: if Q == 0 then Q <= MODULUS-1, else Q <= Q-1.
- Latency: one falling edge from En or Load sampled to Q updated. Inputs must be stable around the falling edge.
- Toggle datapath: T[i] = next[i] ^ Q[i] for every bit. Each bit is updated only by toggling its cell; no direct D-style writes to Q.
- TC = En & ~Reset & ((Up & Q==MODULUS-1) | (~Up & Q==0)). TC is combinational and is valid before the edge on which the wrap occurs.
- Q never leaves 0..MODULUS-1, including after a Load with an out-of-range D.
- Simultaneous Load and En: Load wins.
- Up changing while En=1 takes effect at the next falling edge.

Optional Feature:
TFF_COUNTER_SAT_EN
- Defined: the counter saturates instead of wrapping. Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0. TC still asserts at the boundary per the TC equation above. Load behaviour is unchanged.
- Undefined: wrap-around behaviour as described in Behaviour.

Decomposition:
- Package tff_counter_pkg: DEFAULT_WIDTH=4, DEFAULT_MODULUS=10, and a function max_count(MODULUS) returning MODULUS-1, shared with the bench.
- One sub-module, tff_cell, instantiated WIDTH times. Ports: Clock, Reset, T, Q. Falling-edge behaviour with asynchronous active-high reset to 0. Q toggles when T=1.
- Next-value, wrap/saturate and TC logic live in the top module.

Test Plan:
(All cases: WIDTH=4, MODULUS=10, Clock period 40 ns.)
1. Reset=1 for 10 ns, then Reset=0 with En=0, Load=0 -> Q=0 and TC=0, held across 3 falling edges.
2. En=1, Up=1 from Q=0 -> after 9 falling edges Q=9 and TC=1; 10th edge -> Q=0, TC=0. With SAT_EN: Q stays 9.
3. En=1, Up=0 at Q=0 -> TC=1 before the edge; next falling edge Q=9. With SAT_EN: Q stays 0.
4. Load=1, D=7, En=1 -> Q=7 after the next falling edge. Load=1, D=12 -> Q=0.
5. Counting up, Reset=1 pulsed for 20 ns at Q=5, between edges -> Q=0 immediately and TC=0; after release, first falling edge with En=1, Up=1 gives Q=1.
6. Q=7, En=1, Up=1 -> all four T bits = 1 at the edge; Q=8 afterwards. Q=9 -> 0 toggles bits 0 and 3 only.
